// File: rtl/ov7670_capture.sv
// OV7670 capture: samples the camera bus, packs byte pairs into RGB444
// pixels and writes them in raster order, flagging frame geometry errors.
module ov7670_capture #(
  parameter int unsigned RESOLUTION_WIDTH  = 640,
  parameter int unsigned RESOLUTION_HEIGHT = 480
) (
  input  logic                                                    pclk,
  input  logic                                                    rst_n,
  input  logic                                                    cam_vsync,
  input  logic                                                    cam_href,
  input  logic [7:0]                                              cam_data,
  output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT):0]     w_addr,
  output logic [11:0]                                             w_data,
  output logic                                                    w_en,
  output logic                                                    frame_done,
  output logic                                                    line_err,
  output logic                                                    frame_err
);

  localparam int unsigned AW   = $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT) + 1;
  localparam int unsigned LW   = $clog2(RESOLUTION_HEIGHT) + 1;
  localparam int unsigned BW   = $clog2(2*RESOLUTION_WIDTH) + 2;
  localparam int unsigned NPIX = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
  localparam int unsigned LPB  = 2 * RESOLUTION_WIDTH;

  typedef enum logic [1:0] {WAIT_VS, ARMED, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0]      data_q;
  logic            phase;
  logic [3:0]      red;
  logic [LW-1:0]   line_cnt;
  logic [BW-1:0]   byte_cnt;

  logic            href_rise, href_fall, vs_rise, vs_fall;
  logic            capture, byte_valid, eff_phase, addr_full, line_end, frame_end;
  logic [LW-1:0]   line_cnt_nxt;
  logic [BW-1:0]   byte_cnt_nxt;

  // Input q-stage plus one extra delay for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      vsync_q  <= cam_vsync;
      vsync_qq <= vsync_q;
      href_q   <= cam_href;
      href_qq  <= href_q;
      data_q   <= cam_data;
    end
  end

  // Edge strobes and per-byte decode
  always_comb begin
    href_rise    = href_q & ~href_qq;
    href_fall    = ~href_q & href_qq;
    vs_rise      = vsync_q & ~vsync_qq;
    vs_fall      = ~vsync_q & vsync_qq;
    capture      = (state_q == CAPTURE);
    // a byte seen together with the VSYNC rise belongs to no frame
    byte_valid   = capture & href_q & ~vs_rise;
    eff_phase    = href_rise ? 1'b0 : phase;
    addr_full    = (w_addr == AW'(NPIX));
    line_end     = capture & href_fall;
    frame_end    = capture & vs_rise;
    line_cnt_nxt = line_cnt;
    if (line_end && (line_cnt != {LW{1'b1}})) line_cnt_nxt = line_cnt + LW'(1);
    byte_cnt_nxt = byte_cnt;
    if (href_rise)                         byte_cnt_nxt = BW'(1);
    else if (byte_cnt != {BW{1'b1}})       byte_cnt_nxt = byte_cnt + BW'(1);
  end

  // Frame state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_VS;
    else        state_q <= state_d;
  end

  // Frame next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: if (vsync_q) state_d = ARMED;
      ARMED:   if (vs_fall) state_d = CAPTURE;
      CAPTURE: if (vs_rise) state_d = ARMED;
      default: state_d = WAIT_VS;
    endcase
  end

  // Pixel assembly, write port, line/frame accounting
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr     <= '0;
      w_data     <= 12'h000;
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      phase      <= 1'b0;
      red        <= 4'h0;
      line_cnt   <= '0;
      byte_cnt   <= '0;
    end else begin
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      if (w_en) w_addr <= w_addr + AW'(1);
      if (state_q == ARMED && vs_fall) begin
        w_addr    <= '0;
        line_cnt  <= '0;
        byte_cnt  <= '0;
        phase     <= 1'b0;
        line_err  <= 1'b0;
        frame_err <= 1'b0;
      end else if (capture) begin
        if (byte_valid) begin
          byte_cnt <= byte_cnt_nxt;
          if (!eff_phase) begin
            red   <= data_q[3:0];
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!addr_full) begin
              w_en   <= 1'b1;
              w_data <= {red, data_q};
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        if (line_end) begin
          line_cnt <= line_cnt_nxt;
          phase    <= 1'b0;
          if (byte_cnt != BW'(LPB)) line_err <= 1'b1;
        end
        if (frame_end) begin
          frame_done <= 1'b1;
          phase      <= 1'b0;
          if (line_cnt_nxt != LW'(RESOLUTION_HEIGHT)) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture at a 4x2 geometry.
module tb_ov7670_capture;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [3:0]  w_addr;
  logic [11:0] w_data;
  logic        w_en, frame_done, line_err, frame_err;

  ov7670_capture #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(2)) dut (
    .pclk(pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err));

  always #5 pclk = ~pclk;

  typedef struct {
    int          lines;
    int          nbytes;
    bit          simul;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          exp_wr;
    logic [11:0] exp_data;
    bit          exp_lerr;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_bad = 0;

  // monitor: sole writer of the write log and event counters
  int   wa_q[$];
  int   wd_q[$];
  int   done_cnt = 0;
  int   done_en  = 0;
  int   b2b      = 0;
  logic prev_en  = 1'b0;

  always @(negedge pclk) begin
    if (w_en) begin
      wa_q.push_back(int'(w_addr));
      wd_q.push_back(int'(w_data));
      if (frame_done) done_en <= done_en + 1;
      if (prev_en)    b2b     <= b2b + 1;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    prev_en <= w_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit tail);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? b0 : b1;
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    if (tail) repeat (3) tick();
  endtask

  // expects VSYNC currently high; runs one frame and checks its outcome
  task automatic run_frame(input vec_t v, input string tag);
    int base_w, base_d, base_e, base_b, nw;
    base_w = wa_q.size();
    base_d = done_cnt;
    base_e = done_en;
    base_b = b2b;
    cam_vsync = 1'b0;
    repeat (3) tick();
    chk({tag, "_lerr_clr"}, int'(line_err), 0);
    chk({tag, "_ferr_clr"}, int'(frame_err), 0);
    for (int l = 0; l < v.lines; l++)
      send_line(v.nbytes, v.b0, v.b1, !(v.simul && l == v.lines - 1));
    cam_vsync = 1'b1;
    repeat (4) tick();
    nw = wa_q.size() - base_w;
    chk({tag, "_nwrites"}, nw, v.exp_wr);
    for (int i = 0; i < nw && i < v.exp_wr; i++) begin
      chk({tag, "_addr"}, wa_q[base_w + i], i);
      chk({tag, "_data"}, wd_q[base_w + i], int'(v.exp_data));
    end
    chk({tag, "_done"},     done_cnt - base_d, 1);
    chk({tag, "_done_en"},  done_en - base_e, 0);
    chk({tag, "_b2b"},      b2b - base_b, 0);
    chk({tag, "_lerr"},     int'(line_err), int'(v.exp_lerr));
    chk({tag, "_ferr"},     int'(frame_err), int'(v.exp_ferr));
    chk({tag, "_waddr"},    int'(w_addr), v.exp_wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_w, base_d;
    vecs[0] = '{2,  8, 1'b0, 8'h0A, 8'hBC, 8, 12'hABC, 1'b0, 1'b0};
    vecs[1] = '{2,  7, 1'b0, 8'h03, 8'h45, 6, 12'h345, 1'b1, 1'b0};
    vecs[2] = '{3,  8, 1'b0, 8'hF1, 8'h23, 8, 12'h123, 1'b0, 1'b1};
    vecs[3] = '{1,  8, 1'b0, 8'h0E, 8'hD0, 4, 12'hED0, 1'b0, 1'b1};
    vecs[4] = '{2, 10, 1'b0, 8'h07, 8'h89, 8, 12'h789, 1'b1, 1'b1};
    vecs[5] = '{2,  8, 1'b1, 8'h6C, 8'h00, 8, 12'hC00, 1'b0, 1'b0};

    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) tick();
    chk("rst_waddr", int'(w_addr), 0);
    chk("rst_wdata", int'(w_data), 0);
    chk("rst_wen",   int'(w_en), 0);
    chk("rst_done",  int'(frame_done), 0);
    chk("rst_lerr",  int'(line_err), 0);
    chk("rst_ferr",  int'(frame_err), 0);
    rst_n = 1'b1;
    tick();

    // bytes before any VSYNC are ignored
    base_w = wa_q.size();
    send_line(8, 8'h0A, 8'hBC, 1'b1);
    chk("prevs_nowrite", wa_q.size() - base_w, 0);

    // VSYNC high->low, then one pixel with exact latency
    cam_vsync = 1'b1; repeat (3) tick();
    cam_vsync = 1'b0; repeat (3) tick();
    base_d = done_cnt;
    cam_href = 1'b1; cam_data = 8'h09; tick();
    cam_data = 8'h5A; tick();
    chk("lat_n_wen", int'(w_en), 0);
    cam_href = 1'b0; cam_data = 8'h00; tick();
    chk("lat_n1_wen",   int'(w_en), 1);
    chk("lat_n1_waddr", int'(w_addr), 0);
    chk("lat_n1_wdata", int'(w_data), 12'h95A);
    tick();
    chk("lat_n2_wen",   int'(w_en), 0);
    chk("lat_n2_waddr", int'(w_addr), 1);
    repeat (2) tick();
    cam_vsync = 1'b1; repeat (4) tick();
    chk("lat_done", done_cnt - base_d, 1);
    chk("lat_lerr", int'(line_err), 1);
    chk("lat_ferr", int'(frame_err), 1);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], $sformatf("v%0d", k));

    // reset mid-line between pixel bytes
    cam_vsync = 1'b0; repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? 8'h0A : 8'hBC;
      tick();
    end
    chk("pre_rst_waddr", int'(w_addr), 1);
    chk("pre_rst_wdata", int'(w_data), 12'hABC);
    rst_n = 1'b0;
    #1;
    chk("mrst_waddr", int'(w_addr), 0);
    chk("mrst_wdata", int'(w_data), 0);
    chk("mrst_wen",   int'(w_en), 0);
    chk("mrst_lerr",  int'(line_err), 0);
    chk("mrst_ferr",  int'(frame_err), 0);
    tick();
    rst_n = 1'b1;
    base_w = wa_q.size();
    for (int i = 0; i < 7; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? 8'hBC : 8'h0A;
      tick();
    end
    send_line(8, 8'h0A, 8'hBC, 1'b1);
    chk("mrst_nowrite", wa_q.size() - base_w, 0);
    cam_vsync = 1'b1; repeat (3) tick();
    run_frame(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage: samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) on the camera pixel clock and reassembles byte pairs into 12-bit RGB444 pixels. It writes them sequentially into the video frame buffer, at addresses matching the raster order the VGA output stage reads back (address 0 = top-left, row-major). It also reports frame completion and geometry errors so software or the display side can detect a misconfigured sensor.

## Interface
Parameters:
- RESOLUTION_WIDTH, 640, pixels per line expected from the sensor
- RESOLUTION_HEIGHT, 480, lines per frame expected from the sensor

Ports:
- pclk  input  1  camera pixel clock; sole clock; all logic on posedge
- rst_n  input  1  reset, asynchronous assert, active-low
- cam_vsync  input  1  sensor VSYNC, active-high pulse between frames
- cam_href  input  1  sensor HREF, high while line bytes are valid
- cam_data  input  8  sensor data bus
- w_addr  output  $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)+1  frame buffer write address
- w_data  output  12  pixel {R[3:0],G[3:0],B[3:0]}
- w_en  output  1  write strobe, one cycle per pixel
- frame_done  output  1  one-cycle pulse at end of a captured frame
- line_err  output  1  sticky: some line in current/last frame had byte count ≠ 2*RESOLUTION_WIDTH
- frame_err  output  1  sticky: last frame line count ≠ RESOLUTION_HEIGHT or buffer overflow

## Operation
- Input stage: cam_vsync, cam_href, cam_data registered once (q-stage); all logic below uses q-stage values. Edge detection on cam_href_q and cam_vsync_q against one more delayed copy.
- FSM states: WAIT_VS, ARMED, CAPTURE.
  - WAIT_VS: ignore bus. cam_vsync_q=1 -> ARMED.
  - ARMED: falling edge of cam_vsync_q -> CAPTURE. Also clear w_addr, line/byte counters, line_err, frame_err.
  - CAPTURE: rising edge of cam_vsync_q -> end of frame. Pulse frame_done. Set frame_err if line count ≠ RESOLUTION_HEIGHT. Go to ARMED (VSYNC is already high).
- Pixel assembly (CAPTURE only, while cam_href_q=1):
  - Byte phase toggles each byte; phase forced to 0 on href rising edge.
  - Phase 0 byte: latch low nibble as R.
  - Phase 1 byte: G = byte[7:4], B = byte[3:0]. Issue write of {R,G,B} at w_addr, then increment w_addr.
- Line end (href falling edge in CAPTURE):
  - Increment line count (saturating at 2^($clog2(RESOLUTION_HEIGHT)+1)-1).
  - Byte count ≠ 2*RESOLUTION_WIDTH -> set line_err.
  - Odd trailing byte: discarded, no write.
- w_addr does not rewind per line; a short line shifts subsequent pixels (flagged by line_err, not corrected).
- Overflow: when w_addr = RESOLUTION_WIDTH*RESOLUTION_HEIGHT, further writes are suppressed (w_en stays 0, w_addr holds) and frame_err is set.
- VSYNC rising mid-line: treated as frame end as above. A pending phase-0 byte is discarded, and the partial line is not counted.
- line_err/frame_err hold through ARMED and are cleared only on the next CAPTURE entry.

## Timing
- Reset (async, rst_n=0): state WAIT_VS. w_addr=0, w_data=0, w_en=0, frame_done=0, line_err=0, frame_err=0, byte phase 0, all counters 0, q-stages 0. Release is synchronous to pclk.
- Reset mid-frame: the remainder of that frame is dropped. Capture resumes only after a full VSYNC high→low sequence.
- Latency: second byte of a pixel sampled on pclk edge n (into q-stage). w_en, w_data and w_addr are registered on edge n+1 and valid for one cycle. w_addr increments on edge n+2.
- w_en maximum rate: one pulse per two pclk cycles; never two consecutive cycles high.
- frame_done: high for exactly one cycle, registered on the edge after the cam_vsync_q rising edge is detected. Asserted with the final error flag values, never coincident with w_en.
- Simultaneous href fall and vsync rise: line is closed first (count/err update), then the frame is closed, in the same cycle.

## Test plan
- W=4,H=2, clean frame: VSYNC pulse, then 2 lines of 8 bytes {0x0A,0xBC}… -> 8 writes, addrs 0..7, w_data=0xABC, frame_done pulse, line_err=0, frame_err=0.
- Line of 7 bytes (W=4): 3 writes, last byte discarded, line_err=1 after href fall. Next frame start clears it.
- 3 lines of 8 bytes (W=4,H=2): addrs 0..7 written, 4 writes suppressed, w_addr holds at 8, frame_err=1.
- Bytes presented before the first VSYNC after reset: no w_en. After VSYNC high→low, the next line writes from addr 0.
- rst_n low for 1 cycle mid-line (between pixel byte 0 and 1): all outputs 0 immediately. No write until the next full VSYNC sequence.
- HREF falls on the same cycle VSYNC rises after 2 full lines: frame_done once, frame_err=0, line_err=0.
